// File: rtl/rptr_status.sv
// rptr_status: read-side pointer, address and status flags for the dual-clock FIFO
module rptr_status #(
  parameter int ADDR_WIDTH    = 4,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                  rclk,
  input  logic                  rrst_n,
  input  logic                  rinc,
  input  logic [ADDR_WIDTH:0]   rq2_wptr,
  input  logic                  rerr_clr,
  output logic [ADDR_WIDTH-1:0] raddr,
  output logic [ADDR_WIDTH:0]   rptr,
  output logic                  rempty,
  output logic                  raempty,
  output logic [ADDR_WIDTH:0]   rlevel,
  output logic                  rerr_underflow
);
  localparam logic [ADDR_WIDTH:0] ATH = (ADDR_WIDTH+1)'(AEMPTY_THRESH);
  if (AEMPTY_THRESH < 0 || AEMPTY_THRESH > (1 << ADDR_WIDTH) - 1) begin : g_bad_thresh
    $error("rptr_status: AEMPTY_THRESH out of range");
  end
  logic [ADDR_WIDTH:0] rbin, rbin_nxt, rgray_nxt, wbin_s, lvl_nxt;
  logic rd_en;
  for (genvar i = 0; i <= ADDR_WIDTH; i++) begin : g_g2b
    assign wbin_s[i] = ^rq2_wptr[ADDR_WIDTH:i];
  end
  assign rd_en     = rinc & ~rempty;
  assign rbin_nxt  = rbin + {{ADDR_WIDTH{1'b0}}, rd_en};
  assign rgray_nxt = (rbin_nxt >> 1) ^ rbin_nxt;
  assign lvl_nxt   = wbin_s - rbin_nxt;
  assign raddr     = rbin[ADDR_WIDTH-1:0];
  always_ff @(posedge rclk or negedge rrst_n)
    if (!rrst_n) begin
      rbin           <= '0;
      rptr           <= '0;
      rempty         <= 1'b1;
      raempty        <= 1'b1;
      rlevel         <= '0;
      rerr_underflow <= 1'b0;
    end else begin
      rbin           <= rbin_nxt;
      rptr           <= rgray_nxt;
      rempty         <= rgray_nxt == rq2_wptr;
      rlevel         <= lvl_nxt;
      raempty        <= lvl_nxt <= ATH;
      rerr_underflow <= (rinc & rempty) ? 1'b1 : rerr_clr ? 1'b0 : rerr_underflow;
    end
endmodule

// File: tb/tb_rptr_status.sv
// tb_rptr_status: scoreboard bench comparing rptr_status against a counter-based reference model
module tb_rptr_status;
  logic       rclk = 0, rrst_n = 0, rinc = 0, rerr_clr = 0;
  logic [4:0] rq2_wptr = 0;
  logic [3:0] raddr;
  logic [4:0] rptr, rlevel;
  logic       rempty, raempty, rerr_underflow;

  rptr_status #(.ADDR_WIDTH(4), .AEMPTY_THRESH(2)) dut (
    .rclk(rclk), .rrst_n(rrst_n), .rinc(rinc), .rq2_wptr(rq2_wptr), .rerr_clr(rerr_clr),
    .raddr(raddr), .rptr(rptr), .rempty(rempty), .raempty(raempty), .rlevel(rlevel),
    .rerr_underflow(rerr_underflow));

  always #5 rclk = ~rclk;

  typedef struct {
    logic [3:0] addr;
    logic [4:0] ptr, lvl;
    logic       e, ae, err;
  } exp_t;
  exp_t q[$];
  exp_t mon_e;
  int checks = 0, errors = 0;
  int rd = 0, wr = 0;
  bit m_empty = 1, m_err = 0;

  function automatic logic [4:0] gray(int n);
    logic [4:0] b;
    b = 5'(n);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_vals(string tag);
    chk({tag, "_rempty"}, rempty, 1);
    chk({tag, "_raempty"}, raempty, 1);
    chk({tag, "_rlevel"}, rlevel, 0);
    chk({tag, "_rptr"}, rptr, 0);
    chk({tag, "_raddr"}, raddr, 0);
    chk({tag, "_rerr"}, rerr_underflow, 0);
  endtask

  // One cycle of stimulus; the model predicts the state after the next rising edge.
  task automatic cycle(bit inc, int new_wr, bit clr);
    exp_t x;
    int lvl;
    @(negedge rclk);
    rinc = inc;
    rerr_clr = clr;
    rq2_wptr = gray(new_wr);
    m_err = (inc && m_empty) ? 1 : clr ? 0 : m_err;
    if (inc && !m_empty) rd++;
    wr = new_wr;
    lvl = (wr - rd) & 31;
    m_empty = (lvl == 0);
    x.addr = 4'(rd % 16);
    x.ptr = gray(rd);
    x.lvl = 5'(lvl);
    x.e = m_empty;
    x.ae = (lvl <= 2);
    x.err = m_err;
    q.push_back(x);
  endtask

  always @(posedge rclk) begin
    #1;
    if (rrst_n && q.size() > 0) begin
      mon_e = q.pop_front();
      chk("raddr", raddr, mon_e.addr);
      chk("rptr", rptr, mon_e.ptr);
      chk("rlevel", rlevel, mon_e.lvl);
      chk("rempty", rempty, mon_e.e);
      chk("raempty", raempty, mon_e.ae);
      chk("rerr_underflow", rerr_underflow, mon_e.err);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge rclk);
    @(negedge rclk);
    check_reset_vals("reset");
    rrst_n = 1;
    cycle(0, 0, 0);
    // partial fill and drain
    cycle(0, 3, 0);
    repeat (3) cycle(1, 3, 0);
    // underflow, set-wins, clear
    cycle(1, 3, 0);
    cycle(0, 3, 0);
    cycle(1, 3, 1);
    cycle(0, 3, 1);
    cycle(0, 3, 0);
    // full then wrap through 31 -> 0
    wr = rd + 16;
    cycle(0, wr, 0);
    repeat (16) cycle(1, wr, 0);
    cycle(1, wr, 0);
    cycle(0, rd + 16, 0);
    repeat (16) cycle(1, wr, 0);
    // simultaneous read and write at level 1
    cycle(0, rd + 1, 0);
    cycle(1, wr + 1, 0);
    cycle(1, wr, 0);
    // randomized traffic with the writer never more than a full FIFO ahead
    for (int i = 0; i < 400; i++) begin
      int nw;
      nw = wr;
      if ($urandom_range(0, 1) && (nw - rd) < 16) nw++;
      cycle(1'($urandom_range(0, 1)), nw, 1'($urandom_range(0, 7) == 0));
    end
    // mid-operation asynchronous reset at level 5 with reads pending
    cycle(0, rd + 5, 0);
    cycle(1, wr, 0);
    rinc = 1;
    @(posedge rclk);
    #3;
    rrst_n = 0;
    #1;
    check_reset_vals("async_reset");
    q.delete();
    rd = 0; wr = 0; m_empty = 1; m_err = 0;
    @(negedge rclk);
    rinc = 0;
    rerr_clr = 0;
    rq2_wptr = 0;
    rrst_n = 1;
    cycle(0, 0, 0);
    cycle(0, 2, 0);
    cycle(1, 2, 0);
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge rclk);
    #2;
    chk("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rptr_status.md
# rptr_status

Read-side pointer and status controller for the dual-clock FIFO, running entirely in the read clock domain. It owns the binary and Gray read pointers, generates the RAM read address, and produces registered status flags for the read port: empty, almost-empty, occupancy level and a sticky underflow flag. It consumes the write pointer after it has been synchronized into `rclk`, and drives the Gray read pointer toward the write-domain synchronizer.

## Interface

**Parameters**
- `ADDR_WIDTH`, default 4: FIFO depth is 2^ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits wide.
- `AEMPTY_THRESH`, default 2: `raempty` asserts when the level is ≤ this value. Legal range is 0..2^ADDR_WIDTH-1; violating this is an elaboration-time error.

**Ports**
- `rclk`, input, 1: read clock.
- `rrst_n`, input, 1: reset, asynchronous, active-low.
- `rinc`, input, 1: read request; pops one word when `rempty`=0.
- `rq2_wptr`, input, ADDR_WIDTH+1: Gray write pointer, already synchronized to `rclk`.
- `rerr_clr`, input, 1: clears `rerr_underflow`.
- `raddr`, output, ADDR_WIDTH: binary RAM read address.
- `rptr`, output, ADDR_WIDTH+1: registered Gray read pointer, sent to the write-domain synchronizer.
- `rempty`, output, 1: FIFO empty.
- `raempty`, output, 1: FIFO almost empty.
- `rlevel`, output, ADDR_WIDTH+1: occupancy as seen from the read domain, 0..2^ADDR_WIDTH.
- `rerr_underflow`, output, 1: sticky flag, set when a read is attempted while empty.

## Operation

**Internal state**
- `rbin` holds the binary read pointer (ADDR_WIDTH+1 bits).
- The registered outputs `rptr`, `rempty`, `raempty`, `rlevel` and `rerr_underflow` are also state.

**Combinational next-state logic**
- `rd_en = rinc & ~rempty`.
- `rbin_nxt = rbin + rd_en`, modulo 2^(ADDR_WIDTH+1).
- `rgray_nxt = (rbin_nxt >> 1) ^ rbin_nxt`.
- `wbin_s` = Gray-to-binary conversion of `rq2_wptr` (XOR-prefix from the MSB down).
- `lvl_nxt = wbin_s - rbin_nxt`, modulo 2^(ADDR_WIDTH+1).

**Register updates on each `rclk` rising edge**
- `rbin <= rbin_nxt`
- `rptr <= rgray_nxt`
- `rempty <= (rgray_nxt == rq2_wptr)`
- `rlevel <= lvl_nxt`
- `raempty <= (lvl_nxt <= AEMPTY_THRESH)`

**Address output**
- `raddr = rbin[ADDR_WIDTH-1:0]`. It is a direct register slice, with no combinational path from any input.

**Underflow handling**
- A read with `rinc`=1 while `rempty`=1 does not move the pointer. On the next edge it sets `rerr_underflow`=1.
- If `rerr_clr` and a new underflow occur in the same cycle, set wins.
- Otherwise `rerr_clr`=1 clears the flag to 0 on the next edge.

**Wrap-around**
- `rbin` wraps from 2^(ADDR_WIDTH+1)-1 to 0 with no special casing.
- The Gray MSB difference is what distinguishes "full" from "empty", and the modulo subtraction keeps `rlevel` correct across the wrap.

**Behaviour on an inconsistent input**
- `rq2_wptr` must never lead `rptr` by more than 2^ADDR_WIDTH. If it does, `rlevel` is the raw modulo result and is not clamped.

**Reset (asynchronous, active-low)**
- Values while `rrst_n`=0: `rbin`=0, `rptr`=0, `raddr`=0, `rempty`=1, `raempty`=1, `rlevel`=0, `rerr_underflow`=0.
- Asserting reset mid-operation forces these values immediately.
- Release is synchronous to `rclk`; the first update happens on the first edge after release.

## Timing

- All outputs are registered. None depends combinationally on any input.
- **Read latency:** `rinc` sampled at edge N updates `raddr`, `rptr`, `rempty`, `raempty` and `rlevel` at edge N.
- **Write-visibility latency:** a change on `rq2_wptr` before edge N is reflected in `rempty`, `raempty` and `rlevel` at edge N. The synchronizer latency upstream is not counted here.
- **Simultaneous read and write advance in one cycle:** `rempty` and `rlevel` reflect both. The level is unchanged; empty is evaluated against the new pointers.
- **Last-word read:** a read of the last word at edge N gives `rempty`=1 and `rlevel`=0 at edge N. A further `rinc` in cycle N+1 is therefore an underflow.
- **Pessimism:** `rempty` deasserts no earlier than the synchronized write pointer allows. This is intentional and safe.

## Test plan

All scenarios use ADDR_WIDTH=4 and AEMPTY_THRESH=2.

1. **Reset values:** hold `rrst_n`=0 for 3 cycles, then release. Expect `rempty`=1, `raempty`=1, `rlevel`=0, `rptr`=0, `raddr`=0, `rerr_underflow`=0.
2. **Partial fill and drain:**
   - Set `rq2_wptr`=gray(3)=5'b00010. Next edge: `rempty`=0, `rlevel`=3, `raempty`=0.
   - One `rinc`: `rlevel`=2, `raempty`=1, `raddr`=1.
   - Two more reads: `rempty`=1, `rlevel`=0, `rptr`=gray(3).
3. **Underflow:**
   - With the FIFO empty, pulse `rinc`. Expect `raddr`/`rptr` unchanged and `rerr_underflow`=1, which stays set.
   - Pulse `rerr_clr` and `rinc` together: flag stays 1.
   - Pulse `rerr_clr` alone: flag becomes 0.
4. **Full and wrap:**
   - Set `rq2_wptr`=gray(16)=5'b11000. Expect `rlevel`=16, `rempty`=0.
   - Read 16 words, then repeat with write pointer gray(32 mod 32)=0. Expect `rbin` to wrap 31→0 and `rptr` to pass 5'b10000→5'b00000. `rempty` asserts exactly after each 16th read.
5. **Simultaneous events:** with level 1, in the same cycle advance `rq2_wptr` by 1 and assert `rinc`. Expect `rempty`=0, `rlevel`=1.
6. **Reset mid-operation:** with level 5 and `rinc` active, assert `rrst_n`=0 asynchronously between edges. Outputs return to reset values immediately, without waiting for an `rclk` edge.
